// File: rtl/si_cmd_decoder_pkg.sv
// Shared types for the FT245 command decoder: frame FSM states, captured-byte
// record and marker detection.
package si_cmd_decoder_pkg;

  localparam int SI_CMD_MARKER_BIT = 7;

  typedef enum logic [2:0] {
    ST_ADDR   = 3'd0,
    ST_DATA   = 3'd1,
    ST_COMMIT = 3'd2
  } si_state_e;

  typedef struct packed {
    logic       vld;
    logic [7:0] data;
  } si_byte_t;

  function automatic logic is_marker(input logic [7:0] b);
    return b[SI_CMD_MARKER_BIT];
  endfunction

endpackage

// File: rtl/si_cmd_decoder_if.sv
// Bus bundle between the FT245 receive side / config register bank and the decoder.
// master = byte producer and register-bank observer, slave = decoder.
interface si_cmd_decoder_if #(
  parameter int ADDR_WIDTH = 7,
  parameter int DATA_BYTES = 2
);
  logic [7:0]              rx_data_si;
  logic                    rx_rdy_si;
  logic                    rx_ack_si;
  logic [ADDR_WIDTH-1:0]   cfg_addr;
  logic [8*DATA_BYTES-1:0] cfg_data;
  logic                    cfg_wr_stb;
  logic                    frame_err;

  modport master (
    output rx_data_si, rx_rdy_si,
    input  rx_ack_si, cfg_addr, cfg_data, cfg_wr_stb, frame_err
  );

  modport slave (
    input  rx_data_si, rx_rdy_si,
    output rx_ack_si, cfg_addr, cfg_data, cfg_wr_stb, frame_err
  );
endinterface

// File: rtl/si_byte_sink.sv
// rdy/ack capture for the FT245 simple interface: one registered ack pulse and
// one registered byte_valid per consumed byte.
module si_byte_sink
  import si_cmd_decoder_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       en_i,
  input  logic [7:0] rx_data_i,
  input  logic       rx_rdy_i,
  output logic       rx_ack_o,
  output logic       take_o,
  output si_byte_t   byte_o
);

  logic     ack_q, ack_d;
  si_byte_t byte_q, byte_d;

  // rdy is ignored while ack is high: the producer only drops it after seeing ack
  assign take_o = en_i & rx_rdy_i & ~ack_q;

  always_comb begin
    ack_d       = take_o;
    byte_d.vld  = take_o;
    byte_d.data = take_o ? rx_data_i : byte_q.data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ack_q  <= 1'b0;
      byte_q <= '0;
    end else begin
      ack_q  <= ack_d;
      byte_q <= byte_d;
    end
  end

  assign rx_ack_o = ack_q;
  assign byte_o   = byte_q;

endmodule

// File: rtl/si_cmd_decoder.sv
// Assembles marker-prefixed register-write frames from the FT245 byte stream
// and issues one write strobe per complete frame.
module si_cmd_decoder
  import si_cmd_decoder_pkg::*;
#(
  parameter int ADDR_WIDTH     = 7,
  parameter int DATA_BYTES     = 2,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input logic              clk,
  input logic              rst,
  si_cmd_decoder_if.slave  bus
);

  localparam int DW = 8 * DATA_BYTES;
  localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;
  localparam int BW = $clog2(DATA_BYTES) + 1;

  si_state_e             state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d, cfg_addr_q, cfg_addr_d;
  logic [DW-1:0]         data_q, data_d, cfg_data_q, cfg_data_d;
  logic [BW-1:0]         cnt_q, cnt_d;
  logic [TW-1:0]         to_q, to_d;
  logic                  stb_q, stb_d, err_q, err_d;
  logic                  bad_marker, timeout;
  logic                  take;
  si_byte_t              rx_byte;

  si_byte_sink u_sink (
    .clk       (clk),
    .rst       (rst),
    .en_i      (state_q != ST_COMMIT),
    .rx_data_i (bus.rx_data_si),
    .rx_rdy_i  (bus.rx_rdy_si),
    .rx_ack_o  (bus.rx_ack_si),
    .take_o    (take),
    .byte_o    (rx_byte)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_ADDR;
      addr_q     <= '0;
      data_q     <= '0;
      cnt_q      <= '0;
      to_q       <= '0;
      cfg_addr_q <= '0;
      cfg_data_q <= '0;
      stb_q      <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      cnt_q      <= cnt_d;
      to_q       <= to_d;
      cfg_addr_q <= cfg_addr_d;
      cfg_data_q <= cfg_data_d;
      stb_q      <= stb_d;
      err_q      <= err_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    data_d     = data_q;
    cnt_d      = cnt_q;
    to_d       = '0;
    bad_marker = 1'b0;
    timeout    = 1'b0;
    case (state_q)
      ST_ADDR: begin
        if (rx_byte.vld) begin
          if (is_marker(rx_byte.data)) begin
            addr_d  = rx_byte.data[ADDR_WIDTH-1:0];
            cnt_d   = '0;
            state_d = ST_DATA;
          end else begin
            bad_marker = 1'b1;
          end
        end
      end
      ST_DATA: begin
        if (rx_byte.vld) begin
          data_d = (data_q << 8) | DW'(rx_byte.data);
          cnt_d  = cnt_q + BW'(1);
          if (cnt_q == BW'(DATA_BYTES - 1)) state_d = ST_COMMIT;
        end else if (take) begin
          // a byte being taken this edge beats an expiring timeout
          to_d = '0;
        end else if (to_q == TW'(TIMEOUT_CYCLES - 1)) begin
          timeout = 1'b1;
          state_d = ST_ADDR;
        end else begin
          to_d = to_q + TW'(1);
        end
      end
      ST_COMMIT: state_d = ST_ADDR;
      default:   state_d = ST_ADDR;
    endcase
  end

  always_comb begin
    stb_d      = (state_q == ST_COMMIT);
    err_d      = bad_marker | timeout;
    cfg_addr_d = stb_d ? addr_q : cfg_addr_q;
    cfg_data_d = stb_d ? data_q : cfg_data_q;
  end

  assign bus.cfg_addr   = cfg_addr_q;
  assign bus.cfg_data   = cfg_data_q;
  assign bus.cfg_wr_stb = stb_q;
  assign bus.frame_err  = err_q;

endmodule

// File: tb/tb_si_cmd_decoder.sv
// Directed bench: a 2-byte-data decoder and a 3-byte-data decoder, both with a
// 16-cycle inter-byte timeout.
module tb_si_cmd_decoder;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  si_cmd_decoder_if #(.ADDR_WIDTH(7), .DATA_BYTES(2)) if2 ();
  si_cmd_decoder_if #(.ADDR_WIDTH(7), .DATA_BYTES(3)) if3 ();

  si_cmd_decoder #(.ADDR_WIDTH(7), .DATA_BYTES(2), .TIMEOUT_CYCLES(16)) u_dut2 (
    .clk (clk), .rst (rst), .bus (if2.slave)
  );
  si_cmd_decoder #(.ADDR_WIDTH(7), .DATA_BYTES(3), .TIMEOUT_CYCLES(16)) u_dut3 (
    .clk (clk), .rst (rst), .bus (if3.slave)
  );

  int n_chk = 0, n_pass = 0;
  int n_ack2 = 0, n_stb2 = 0, n_err2 = 0, n_err3 = 0;
  logic [30:0] q3[$];

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", tag, act, exp);
  endtask

  always @(negedge clk) begin
    if (if2.rx_ack_si)  n_ack2++;
    if (if2.cfg_wr_stb) n_stb2++;
    if (if2.frame_err)  n_err2++;
    if (if3.frame_err)  n_err3++;
    if (if3.cfg_wr_stb) q3.push_back({if3.cfg_addr, if3.cfg_data});
  end

  // hold=1 models a registered producer that keeps rdy up through the ack cycle
  task automatic send2(input logic [7:0] b, input bit hold);
    int t = 0;
    if2.rx_data_si = b;
    if2.rx_rdy_si  = 1'b1;
    do begin @(negedge clk); t++; end while (!if2.rx_ack_si && t < 50);
    chk("ack2", {31'd0, if2.rx_ack_si}, 32'd1);
    if (hold) begin
      @(posedge clk); #1;
      if2.rx_rdy_si = 1'b0;
      @(negedge clk);
    end else begin
      if2.rx_rdy_si = 1'b0;
    end
  endtask

  task automatic send3(input logic [7:0] b);
    int t = 0;
    if3.rx_data_si = b;
    if3.rx_rdy_si  = 1'b1;
    do begin @(negedge clk); t++; end while (!if3.rx_ack_si && t < 50);
    chk("ack3", {31'd0, if3.rx_ack_si}, 32'd1);
    if3.rx_rdy_si = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic clr_cnt();
    n_ack2 = 0; n_stb2 = 0; n_err2 = 0;
  endtask

  initial begin
    int t;
    if2.rx_data_si = '0; if2.rx_rdy_si = 1'b0;
    if3.rx_data_si = '0; if3.rx_rdy_si = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_ack",  {31'd0, if2.rx_ack_si}, 32'd0);
    chk("rst_stb",  {31'd0, if2.cfg_wr_stb}, 32'd0);
    chk("rst_err",  {31'd0, if2.frame_err}, 32'd0);
    chk("rst_addr", {25'd0, if2.cfg_addr}, 32'd0);
    chk("rst_data", {16'd0, if2.cfg_data}, 32'd0);
    clr_cnt();

    // 1: basic frame and strobe latency
    send2(8'h85, 0); send2(8'h12, 0); send2(8'h34, 0);
    t = 0;
    do begin @(negedge clk); t++; end while (!if2.cfg_wr_stb && t < 10);
    chk("t1_lat",  t, 2);
    chk("t1_addr", {25'd0, if2.cfg_addr}, 32'h05);
    chk("t1_data", {16'd0, if2.cfg_data}, 32'h1234);
    idle(5);
    chk("t1_nstb", n_stb2, 1);
    chk("t1_nerr", n_err2, 0);
    chk("t1_nack", n_ack2, 3);
    chk("t1_hold_addr", {25'd0, if2.cfg_addr}, 32'h05);
    chk("t1_hold_data", {16'd0, if2.cfg_data}, 32'h1234);
    clr_cnt();

    // 2: rdy held through the ack cycle must not double-consume
    send2(8'h90, 1); send2(8'hBE, 1); send2(8'hEF, 1);
    idle(5);
    chk("t2_nack", n_ack2, 3);
    chk("t2_nstb", n_stb2, 1);
    chk("t2_addr", {25'd0, if2.cfg_addr}, 32'h10);
    chk("t2_data", {16'd0, if2.cfg_data}, 32'hBEEF);
    clr_cnt();

    // 3: missing marker then resync
    send2(8'h12, 0); send2(8'h85, 0); send2(8'hAB, 0); send2(8'hCD, 0);
    idle(5);
    chk("t3_nerr", n_err2, 1);
    chk("t3_nstb", n_stb2, 1);
    chk("t3_addr", {25'd0, if2.cfg_addr}, 32'h05);
    chk("t3_data", {16'd0, if2.cfg_data}, 32'hABCD);
    clr_cnt();

    // 4: inter-byte timeout, then a fresh frame
    send2(8'h81, 0); send2(8'h55, 0);
    t = 0;
    do begin @(negedge clk); t++; end while (!if2.frame_err && t < 40);
    chk("t4_to_cyc", t, 17);
    idle(5);
    chk("t4_nerr", n_err2, 1);
    chk("t4_nstb", n_stb2, 0);
    send2(8'h82, 0); send2(8'h00, 0); send2(8'h01, 0);
    idle(5);
    chk("t4_nstb2", n_stb2, 1);
    chk("t4_addr", {25'd0, if2.cfg_addr}, 32'h02);
    chk("t4_data", {16'd0, if2.cfg_data}, 32'h0001);
    clr_cnt();

    // 5: reset mid-frame
    send2(8'h83, 0); send2(8'h77, 0);
    @(posedge clk); #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("t5_addr0", {25'd0, if2.cfg_addr}, 32'd0);
    chk("t5_data0", {16'd0, if2.cfg_data}, 32'd0);
    send2(8'h84, 0); send2(8'hDE, 0); send2(8'hAD, 0);
    idle(5);
    chk("t5_nstb", n_stb2, 1);
    chk("t5_nerr", n_err2, 0);
    chk("t5_addr", {25'd0, if2.cfg_addr}, 32'h04);
    chk("t5_data", {16'd0, if2.cfg_data}, 32'hDEAD);

    // 6: three data bytes, then ten back-to-back frames
    q3.delete();
    send3(8'hFF); send3(8'h01); send3(8'h02); send3(8'h03);
    for (int i = 0; i < 10; i++) begin
      send3(8'h90 + 8'(i)); send3(8'(i)); send3(8'(i * 3)); send3(8'hF0 ^ 8'(i));
    end
    idle(6);
    chk("t6_n", q3.size(), 11);
    chk("t6_nerr", n_err3, 0);
    if (q3.size() == 11) begin
      chk("t6_f0", {1'b0, q3[0]}, {1'b0, 7'h7F, 24'h010203});
      for (int i = 0; i < 10; i++)
        chk($sformatf("t6_f%0d", i + 1), {1'b0, q3[i+1]},
            {1'b0, 7'(16 + i), 8'(i), 8'(i * 3), 8'hF0 ^ 8'(i)});
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
endmodule
